distribuidor_vc4: RTL and testbench
===================================

// Module: distribuidor_vc4
// PURPOSE
//  Write-side counterpart of the 4-FIFO weighted pop arbiter. Drains one upstream FIFO
//  (registered read, data valid the cycle after pop), decodes the 2-bit class field of each
//  word and pushes the word into one of four VC FIFOs (P0..P3), which the arbiter later drains.
//  Backpressure per lane via almost_full; at most one word in flight; no word is ever dropped.
// PARAMETERS
//  WORD_W   6  width of data word
//  CLS_LSB  4  LSB index of 2-bit class field in word (class = word[CLS_LSB+1:CLS_LSB])
//  CNT_W    8  width of each per-lane counter (DISPATCH_CNT_EN only)
// PORTS
//  clk          in   1          clock, all state on posedge
//  reset        in   1          synchronous, active-high
//  in_empty     in   1          upstream FIFO empty
//  in_data      in   WORD_W     upstream read data, valid cycle after in_pop
//  in_pop       out  1          upstream pop (combinational)
//  almost_full  in   4          per-lane almost_full of VC FIFOs P0..P3
//  push         out  4          one-hot push to VC FIFOs (registered)
//  push_data    out  WORD_W     data for push (registered)
//  idle         out  1          1 when no word held and no fetch outstanding
//  lane_cnt     out  4*CNT_W    per-lane pushed-word counters, lane k at [k*CNT_W +: CNT_W]
//                               (present only with DISPATCH_CNT_EN)
// BEHAVIOUR
//  - Reset: state=IDLE, push=0, push_data=0, idle=1, lane_cnt=0; in_pop forced 0 while reset=1.
//  - States: IDLE (nothing held), LOAD (word arriving on in_data), HOLD (word held in hold/cls).
//  - in_pop = !reset & !in_empty & (state==IDLE | (state==HOLD & !almost_full[cls])).
//  - IDLE: in_pop=1 -> LOAD; else stay. push<=0.
//  - LOAD: hold<=in_data, cls<=in_data[CLS_LSB+:2]; -> HOLD. push<=0.
//  - HOLD, almost_full[cls]=0: push<=1<<cls, push_data<=hold; next LOAD if in_pop else IDLE.
//  - HOLD, almost_full[cls]=1: stall; push<=0, push_data keeps value, hold/cls unchanged, in_pop=0.
//  - almost_full of other lanes never blocks the held word (no head-of-line stall on lane != cls).
//  - Latency: in_pop at t -> LOAD t+1 -> HOLD t+2 -> push visible t+3. Throughput: 1 word / 2 cycles
//    (back-to-back: push pulses every 2nd cycle while upstream non-empty and lane free).
//  - push is a 1-cycle pulse per word; never more than one bit set; push=0 outside HOLD-success.
//  - almost_full sampled only in HOLD; rising in LOAD has no effect until HOLD.
//  - in_empty rising in LOAD/HOLD: held word still delivered, then IDLE.
//  - Reset mid-operation (LOAD/HOLD): held/arriving word discarded, no push; upstream pop already
//    issued is lost (upstream FIFO assumed reset together).
//  - idle = (state==IDLE); combinational from state.
// CONFIGURATION
//  DISPATCH_CNT_EN defined: lane_cnt port present; lane k counter +1 on each cycle push[k]=1,
//    saturates at 2^CNT_W-1 (no wrap); cleared only by reset.
//  DISPATCH_CNT_EN undefined: no lane_cnt port, no counter logic; all other behaviour identical.
// TESTING
//  1 reset=1 3 cycles, in_empty=0 -> in_pop=0, push=0, push_data=0, idle=1; release -> in_pop=1 cycle 1.
//  2 single word 6'b10_0101 (cls=2), almost_full=0 -> push=4'b0100, push_data=6'b100101 exactly
//    3 cycles after in_pop; idle returns 1 next cycle.
//  3 four words cls 0,1,2,3 back-to-back, in_empty=0 -> push 0001,0010,0100,1000 on alternate cycles.
//  4 word cls=1, almost_full=4'b0010 for 5 cycles -> push=0 and in_pop=0 during stall, push=4'b0010
//    1 cycle after almost_full[1] drops; almost_full=4'b1101 with cls=1 -> no stall.
//  5 reset asserted in HOLD -> no push that cycle or after; state IDLE, idle=1.
//  6 DISPATCH_CNT_EN, CNT_W=2: 5 words cls=3 -> lane_cnt[3]=3 (saturated), lanes 0..2 = 0.

Source files
------------

// File: rtl/distribuidor_vc4.sv
// Write-side dispatcher: drains one upstream FIFO and steers each word to VC FIFO P0..P3 by its class.
// Optional per-lane push counters are built when DISPATCH_CNT_EN is defined.
module distribuidor_vc4 #(
  parameter int WORD_W  = 6,
  parameter int CLS_LSB = 4
`ifdef DISPATCH_CNT_EN
  , parameter int CNT_W = 8
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_empty,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_pop,
  input  logic [3:0]        almost_full,
  output logic [3:0]        push,
  output logic [WORD_W-1:0] push_data,
  output logic              idle
`ifdef DISPATCH_CNT_EN
  , output logic [4*CNT_W-1:0] lane_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   hold_q, hold_d;
  logic [1:0]          cls_q, cls_d;
  logic [3:0]          push_q, push_d;
  logic [WORD_W-1:0]   push_data_q, push_data_d;
  logic                lane_free;

  // Only the held word's own lane can stall it; other lanes' almost_full is ignored.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    cls_d       = cls_q;
    push_d      = 4'b0000;
    push_data_d = push_data_q;
    lane_free   = !almost_full[cls_q];
    in_pop      = !reset && !in_empty &&
                  ((state_q == S_IDLE) || ((state_q == S_HOLD) && lane_free));

    case (state_q)
      S_IDLE: begin
        if (in_pop) state_d = S_LOAD;
      end
      S_LOAD: begin
        hold_d  = in_data;
        cls_d   = in_data[CLS_LSB +: 2];
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (lane_free) begin
          push_d      = 4'b0001 << cls_q;
          push_data_d = hold_q;
          state_d     = in_pop ? S_LOAD : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      push_q      <= 4'b0000;
      push_data_q <= '0;
    end else begin
      state_q     <= state_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
    end
  end

  // Held word and class are pure data; a reset returns to IDLE, which never reads them.
  always_ff @(posedge clk) begin
    hold_q <= hold_d;
    cls_q  <= cls_d;
  end

  assign push      = push_q;
  assign push_data = push_data_q;
  assign idle      = (state_q == S_IDLE);

`ifdef DISPATCH_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];

  // Counters follow the registered push pulse and saturate instead of wrapping.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      cnt_d[k] = cnt_q[k];
      if (push_q[k] && (cnt_q[k] != CNT_MAX)) cnt_d[k] = cnt_q[k] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (reset) cnt_q[k] <= '0;
      else       cnt_q[k] <= cnt_d[k];
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_lane_cnt
    assign lane_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_distribuidor_vc4.sv
// Directed bench for distribuidor_vc4 with a small registered-read upstream FIFO model.
// Lane-counter checks are included when DISPATCH_CNT_EN is defined (instance uses CNT_W=2).
module tb_distribuidor_vc4;

  localparam int WORD_W = 6;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_empty;
  logic [WORD_W-1:0] in_data;
  logic              in_pop;
  logic [3:0]        almost_full;
  logic [3:0]        push;
  logic [WORD_W-1:0] push_data;
  logic              idle;
`ifdef DISPATCH_CNT_EN
  logic [7:0]        lane_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Upstream FIFO model: words written by the stimulus, read one cycle after pop.
  logic [WORD_W-1:0] mem [0:31];
  int wr_n = 0;
  int rd_n = 0;

  always #5 clk = ~clk;

  assign in_empty = (rd_n == wr_n);

  always @(posedge clk) begin
    if (in_pop) begin
      in_data <= mem[rd_n];
      rd_n    <= rd_n + 1;
    end
  end

  distribuidor_vc4 #(
    .WORD_W (WORD_W),
    .CLS_LSB(4)
`ifdef DISPATCH_CNT_EN
    , .CNT_W(2)
`endif
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_empty   (in_empty),
    .in_data    (in_data),
    .in_pop     (in_pop),
    .almost_full(almost_full),
    .push       (push),
    .push_data  (push_data),
    .idle       (idle)
`ifdef DISPATCH_CNT_EN
    , .lane_cnt (lane_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    in_data     = '0;
    almost_full = 4'b0000;
    reset       = 1'b1;
    mem[0]      = 6'b10_0101;
    wr_n        = 1;

    // Reset held three cycles with upstream non-empty.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_in_pop", in_pop, 0);
      chk("rst_push", push, 0);
      chk("rst_push_data", push_data, 0);
      chk("rst_idle", idle, 1);
    end

    // Single word, class 2.
    reset = 1'b0;
    #1;
    chk("t1_pop_after_release", in_pop, 1);
    tick();
    chk("t2_load_idle", idle, 0);
    chk("t2_load_push", push, 0);
    tick();
    chk("t2_hold_push", push, 0);
    tick();
    chk("t2_push", push, 4'b0100);
    chk("t2_push_data", push_data, 6'b100101);
    chk("t2_idle_back", idle, 1);
    tick();
    chk("t2_pulse_end", push, 0);

    // Four words of class 0..3 back to back.
    mem[1] = 6'b00_0011;
    mem[2] = 6'b01_1010;
    mem[3] = 6'b10_0001;
    mem[4] = 6'b11_1111;
    wr_n   = 5;
    #1;
    chk("t3_pop0", in_pop, 1);
    for (int c = 1; c <= 9; c++) begin
      logic [3:0] ep;
      logic [5:0] ed;
      tick();
      ep = 4'b0000;
      ed = 6'b0;
      if ((c >= 3) && (c % 2 == 1)) begin
        ep = 4'b0001 << ((c - 3) / 2);
        ed = mem[1 + (c - 3) / 2];
      end
      chk("t3_push", push, ep);
      if (ep != 4'b0000) chk("t3_push_data", push_data, ed);
      chk("t3_in_pop", in_pop, ((c % 2 == 0) && (c <= 6)) ? 1 : 0);
    end
    chk("t3_idle_end", idle, 1);

    // Stall on own lane, then release; second word queued behind it.
    mem[5]      = 6'b01_0110;
    mem[6]      = 6'b00_1001;
    wr_n        = 7;
    almost_full = 4'b0010;
    #1;
    chk("t4_pop", in_pop, 1);
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("t4_stall_push", push, 0);
      chk("t4_stall_in_pop", in_pop, 0);
      tick();
    end
    chk("t4_stall_last", push, 0);
    chk("t4_not_idle", idle, 0);
    almost_full = 4'b0000;
    #1;
    chk("t4_release_pop", in_pop, 1);
    tick();
    chk("t4_push", push, 4'b0010);
    chk("t4_push_data", push_data, 6'b010110);
    tick();
    chk("t4_gap", push, 0);
    tick();
    chk("t4_push2", push, 4'b0001);
    chk("t4_push2_data", push_data, 6'b001001);

    // Other lanes almost_full: class 1 word must not stall.
    mem[7]      = 6'b01_1100;
    wr_n        = 8;
    almost_full = 4'b1101;
    #1;
    chk("t4b_pop", in_pop, 1);
    tick();
    tick();
    chk("t4b_hold_push", push, 0);
    tick();
    chk("t4b_push", push, 4'b0010);
    chk("t4b_push_data", push_data, 6'b011100);
    almost_full = 4'b0000;

    // Reset while holding a word: no push afterwards.
    mem[8] = 6'b11_0001;
    wr_n   = 9;
    #1;
    chk("t5_pop", in_pop, 1);
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("t5_pop_in_reset", in_pop, 0);
    tick();
    chk("t5_push", push, 0);
    chk("t5_idle", idle, 1);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_after_push", push, 0);
      chk("t5_after_idle", idle, 1);
    end

`ifdef DISPATCH_CNT_EN
    // Five class-3 words saturate a 2-bit counter.
    for (int i = 0; i < 5; i++) mem[9 + i] = 6'b11_0000 | 6'(i);
    wr_n = 14;
    for (int i = 0; i < 14; i++) tick();
    chk("t6_lane_cnt", lane_cnt, 8'hC0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
